// File: rtl/pixel_word_packer_if.sv
// Word-side stream of pixel_word_packer: show-ahead head word with a valid/ready handshake.
// The packer drives the master modport and the memory-write / bus consumer drives the slave modport.
interface pixel_word_packer_if;
    logic        word_valid;
    logic [31:0] word;
    logic        last;
    logic        word_ready;

    modport master (
        output word_valid,
        output word,
        output last,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word,
        input  last,
        output word_ready
    );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs four 8-bit pixels little-endian into 32-bit words behind a show-ahead FIFO with sticky overflow.
// Define PACKER_FRAME_LAST_EN to add col/row tracking that flushes and flags the final word of each frame.
module pixel_word_packer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 360,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [7:0]          pixel_i,
    output logic                overflow_o,
    pixel_word_packer_if.master word_if
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Bytes below the lane come from the accumulator; bytes above are zero padding.
    function automatic logic [31:0] merge_byte(input logic [31:0] acc,
                                               input logic [1:0]  lane_sel,
                                               input logic [7:0]  px);
        logic [31:0] res;
        res = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(lane_sel)) begin
                res[8*b +: 8] = acc[8*b +: 8];
            end else if (b == int'(lane_sel)) begin
                res[8*b +: 8] = px;
            end
        end
        return res;
    endfunction

    logic [1:0]       lane;
    logic [31:0]      pack_p0;
    logic [31:0]      push_word_p0;
    logic             push_last_p0;
    logic             vld_p0;

    logic [32:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // ---- stage p0: lane accumulation and push decision ----
    assign push_word_p0 = merge_byte(pack_p0, lane, pixel_i);

`ifdef PACKER_FRAME_LAST_EN
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_end;
    logic             frame_end;

    assign col_end   = (col == COL_W'(IMG_W - 1));
    assign frame_end = col_end && (row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
        end else if (valid_i) begin
            if (col_end) begin
                col <= '0;
                row <= frame_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // The frame's final pixel flushes a partial word so the next frame starts at lane 0.
    assign push_last_p0 = frame_end;
    assign vld_p0       = valid_i && ((lane == 2'd3) || frame_end);
`else
    assign push_last_p0 = 1'b0;
    assign vld_p0       = valid_i && (lane == 2'd3);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane <= '0;
        end else if (valid_i) begin
            lane <= vld_p0 ? 2'd0 : lane + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            pack_p0 <= push_word_p0;
        end
    end

    // ---- stage p1: word FIFO ----
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = word_if.word_valid && word_if.word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign wr_en = vld_p0 && (!full || pop);
    assign drop  = vld_p0 && full && !pop;

    always_comb begin
        count_nxt = count;
        unique case ({wr_en, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {push_last_p0, push_word_p0};
        end
    end

    // Storage is never cleared; outputs are gated so an empty FIFO presents zeros.
    assign word_if.word_valid = (count != '0);
    assign word_if.word       = word_if.word_valid ? fifo_mem[rd_ptr][31:0] : 32'd0;
    assign word_if.last       = word_if.word_valid ? fifo_mem[rd_ptr][32]   : 1'b0;

endmodule
